// File: rtl/s2p_rx_ctrl.sv
// Frame sequencer for the 9-bit serial-to-parallel receive register: finds the
// start bit, times mid-bit shift pulses, strobes the read and runs valid/ack.
module s2p_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_en,
    input  logic serial_in,
    output logic sr_clk,
    output logic sr_rx_en,
    output logic sr_read,
    output logic rx_valid,
    input  logic rx_ack,
    output logic frame_err,
    output logic overrun,
    output logic busy
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic             stop_q, stop_d;
    logic [1:0]       sync_q;
    logic             s_in;
    logic             sr_rx_en_q, sr_rx_en_d;
    logic             sr_clk_q, sr_clk_d;
    logic             sr_read_q, sr_read_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;

    assign s_in = sync_q[1];

    // Synchroniser resets to the idle level so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            stop_q      <= 1'b0;
            sr_rx_en_q  <= 1'b0;
            sr_clk_q    <= 1'b1;
            sr_read_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            stop_q      <= stop_d;
            sr_rx_en_q  <= sr_rx_en_d;
            sr_clk_q    <= sr_clk_d;
            sr_read_q   <= sr_read_d;
            frame_err_q <= frame_err_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        stop_d      = stop_q;
        sr_rx_en_d  = sr_rx_en_q;
        sr_clk_d    = 1'b1;
        sr_read_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                sr_rx_en_d = rx_en;
                if (sr_rx_en_q && !s_in) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (tcnt_q == HALF_LAST) begin
                    tcnt_d = '0;
                    if (!s_in) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (tcnt_q == BIT_LAST) begin
                    tcnt_d = '0;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == LAST_DATA) begin
                        state_d = STOP;
                    end
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (tcnt_q == BIT_LAST) begin
                    tcnt_d  = '0;
                    stop_d  = s_in;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
        endcase

        // Strobes decoded from next state and registered, so they are glitch-free
        // yet still coincide with the cycle the current state occupies.
        if ((state_d == DATA || state_d == STOP) && tcnt_d == BIT_LAST) begin
            sr_clk_d = 1'b0;
        end
        sr_read_d   = (state_d == DONE) && stop_d;
        frame_err_d = (state_d == DONE) && !stop_d;

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        // A byte finishing in the same cycle as an ack replaces the taken byte cleanly
        if (state_q == DONE && stop_q) begin
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
            rx_valid_d = 1'b1;
        end
    end

    assign sr_clk    = sr_clk_q;
    assign sr_rx_en  = sr_rx_en_q;
    assign sr_read   = sr_read_q;
    assign frame_err = frame_err_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_s2p_rx_ctrl.sv
// Bench for s2p_rx_ctrl: models the external 9-bit S2P register, checks a vector
// table, hand-written corner sequences and random frames against a byte-level model.
module tb_s2p_rx_ctrl;

    localparam int CPB   = 16;
    localparam int SYNC  = 2;
    localparam int LAT   = CPB / 2 + 9 * CPB + 2;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset, rx_en, serial_in, rx_ack;
    logic sr_clk, sr_rx_en, sr_read, rx_valid, frame_err, overrun, busy;

    always #5 clk = ~clk;

    s2p_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_en     (rx_en),
        .serial_in (serial_in),
        .sr_clk    (sr_clk),
        .sr_rx_en  (sr_rx_en),
        .sr_read   (sr_read),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // External shift register: shifts the raw line on sr_clk falling, read copies [8:1]
    logic [8:0] s2p_buf = '0;
    logic [7:0] s2p_out = '0;
    always @(negedge sr_clk) if (sr_rx_en === 1'b1) s2p_buf <= {s2p_buf[7:0], serial_in};
    always @(posedge clk) if (sr_read === 1'b1) s2p_out <= s2p_buf[8:1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses = 0, reads = 0, ferrs = 0, busy_cyc = 0, rise_cyc = -1;
    int wide_clk = 0, wide_rd = 0, wide_fe = 0;
    int pulse_q[$];
    logic prev_lo = 1'b0, prev_rd = 1'b0, prev_fe = 1'b0, prev_v = 1'b0;

    always @(negedge clk) begin
        if (sr_clk === 1'b0) begin
            pulses <= pulses + 1;
            pulse_q.push_back(cyc);
            if (prev_lo) wide_clk <= wide_clk + 1;
        end
        if (sr_read === 1'b1) begin
            reads <= reads + 1;
            if (prev_rd) wide_rd <= wide_rd + 1;
        end
        if (frame_err === 1'b1) begin
            ferrs <= ferrs + 1;
            if (prev_fe) wide_fe <= wide_fe + 1;
        end
        if (rx_valid === 1'b1 && !prev_v) rise_cyc <= cyc;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
        prev_lo <= (sr_clk === 1'b0);
        prev_rd <= (sr_read === 1'b1);
        prev_fe <= (frame_err === 1'b1);
        prev_v  <= (rx_valid === 1'b1);
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
    endtask

    // ev_kind: 0 none, 1 async reset at ev_at (returns early), 2 drop rx_en, 3 ack for one clk
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int ev_at,
                              input int ev_kind, output int c0);
        logic [9:0] bits;
        bits = {1'b0, d, stopb};
        c0 = cyc;
        for (int i = 0; i < FRAME; i++) begin
            serial_in = bits[9 - i / CPB];
            if (ev_kind == 1 && i == ev_at) begin
                #2 reset = 1'b0;
                #1;
                return;
            end
            if (ev_kind == 2 && i == ev_at) rx_en = 1'b0;
            if (ev_kind == 3 && i == ev_at) rx_ack = 1'b1;
            if (ev_kind == 3 && i == ev_at + 1) rx_ack = 1'b0;
            step(1);
        end
        serial_in = 1'b1;
    endtask

    // Byte-level reference: a pending byte, its value and the overrun flag
    logic       m_valid, m_ovr;
    logic [7:0] m_data;

    function automatic void m_take();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endfunction

    function automatic void m_frame(input logic [7:0] d, input logic stopb);
        if (stopb) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = d;
        end
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        logic       ack_after;
        logic       exp_valid;
        logic [7:0] exp_out;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0, r0, f0, b0, gap_bad, mode;
        logic [7:0] d;
        logic       sb;

        tbl[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
        tbl[3] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0};
        tbl[5] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0};
        tbl[6] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0};

        reset = 1'b1; rx_en = 1'b1; serial_in = 1'b1; rx_ack = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst sr_clk", sr_clk, 1);
        check("rst sr_rx_en", sr_rx_en, 0);
        check("rst sr_read", sr_read, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overrun", overrun, 0);
        check("rst busy", busy, 0);
        step(3);
        check("rst hold sr_rx_en", sr_rx_en, 0);
        reset = 1'b1;

        // Idle line for 100 clocks
        step(100);
        check("idle pulses", pulses, 0);
        check("idle busy cycles", busy_cyc, 0);
        check("idle rx_valid", rx_valid, 0);
        check("idle sr_rx_en", sr_rx_en, 1);
        check("idle frame_err count", ferrs, 0);

        // 0xA5 good frame: pulse timing, latency, ack
        p0 = pulses; r0 = reads; f0 = ferrs;
        send_frame(8'hA5, 1'b1, 0, 0, c0);
        check("A5 pulse count", pulses - p0, 9);
        check("A5 first pulse offset", pulse_q[p0] - c0, SYNC + CPB / 2 + CPB);
        gap_bad = 0;
        for (int j = 1; j < 9; j++) if (pulse_q[p0 + j] - pulse_q[p0 + j - 1] != CPB) gap_bad++;
        check("A5 pulse spacing errors", gap_bad, 0);
        check("A5 sr_read count", reads - r0, 1);
        check("A5 frame_err count", ferrs - f0, 0);
        check("A5 rx_valid latency", rise_cyc - c0, SYNC + LAT);
        check("A5 rx_valid", rx_valid, 1);
        check("A5 s2p out", s2p_out, 8'hA5);
        check("A5 overrun", overrun, 0);
        do_ack();
        check("A5 ack clears rx_valid", rx_valid, 0);

        // Start-bit glitch of 4 clocks
        p0 = pulses; f0 = ferrs; b0 = busy_cyc;
        serial_in = 1'b0;
        step(4);
        serial_in = 1'b1;
        step(40);
        check("glitch pulses", pulses - p0, 0);
        check("glitch frame_err", ferrs - f0, 0);
        check("glitch busy cycles", busy_cyc - b0, CPB / 2);
        check("glitch busy now", busy, 0);

        for (int i = 0; i < 7; i++) begin
            p0 = pulses; r0 = reads; f0 = ferrs;
            send_frame(tbl[i].data, tbl[i].stopb, 0, 0, c0);
            check($sformatf("tbl%0d pulses", i), pulses - p0, 9);
            check($sformatf("tbl%0d reads", i), reads - r0, {31'd0, tbl[i].stopb});
            check($sformatf("tbl%0d frame_err", i), ferrs - f0, {31'd0, !tbl[i].stopb});
            check($sformatf("tbl%0d rx_valid", i), rx_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d s2p out", i), s2p_out, tbl[i].exp_out);
            check($sformatf("tbl%0d overrun", i), overrun, tbl[i].exp_ovr);
            if (tbl[i].ack_after) begin
                do_ack();
                check($sformatf("tbl%0d ack rx_valid", i), rx_valid, 0);
                check($sformatf("tbl%0d ack overrun", i), overrun, 0);
            end
        end

        // rx_en dropped mid-frame: frame completes, then receiver stays idle
        p0 = pulses;
        send_frame(8'h5A, 1'b1, 40, 2, c0);
        check("rxen-drop pulses", pulses - p0, 9);
        check("rxen-drop rx_valid", rx_valid, 1);
        check("rxen-drop s2p out", s2p_out, 8'h5A);
        check("rxen-drop sr_rx_en", sr_rx_en, 0);
        p0 = pulses; b0 = busy_cyc; r0 = reads;
        send_frame(8'h99, 1'b1, 0, 0, c0);
        check("rxen-off pulses", pulses - p0, 0);
        check("rxen-off busy", busy_cyc - b0, 0);
        check("rxen-off reads", reads - r0, 0);
        check("rxen-off rx_valid kept", rx_valid, 1);
        rx_en = 1'b1;
        step(3);
        check("rxen-on sr_rx_en", sr_rx_en, 1);
        do_ack();
        check("rxen-on ack", rx_valid, 0);

        m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            sb = ($urandom_range(3) != 0);
            mode = $urandom_range(2);
            if (mode == 1) begin
                do_ack();
                m_take();
            end
            step($urandom_range(5));
            p0 = pulses; r0 = reads; f0 = ferrs;
            send_frame(d, sb, 155, (mode == 2) ? 3 : 0, c0);
            if (mode == 2) m_take();
            m_frame(d, sb);
            check($sformatf("rnd%0d pulses", k), pulses - p0, 9);
            check($sformatf("rnd%0d reads", k), reads - r0, {31'd0, sb});
            check($sformatf("rnd%0d frame_err", k), ferrs - f0, {31'd0, !sb});
            check($sformatf("rnd%0d rx_valid", k), rx_valid, m_valid);
            check($sformatf("rnd%0d overrun", k), overrun, m_ovr);
            if (m_valid) check($sformatf("rnd%0d s2p out", k), s2p_out, m_data);
        end

        // Reset during data bit 4 of 0xFF with a byte pending
        send_frame(8'h81, 1'b1, 0, 0, c0);
        check("pre-reset rx_valid", rx_valid, 1);
        b0 = busy_cyc;
        send_frame(8'hFF, 1'b1, 5 * CPB + CPB / 2, 1, c0);
        check("mid busy before reset", (busy_cyc - b0) > 0, 1);
        check("mid rst sr_clk", sr_clk, 1);
        check("mid rst sr_rx_en", sr_rx_en, 0);
        check("mid rst sr_read", sr_read, 0);
        check("mid rst rx_valid", rx_valid, 0);
        check("mid rst frame_err", frame_err, 0);
        check("mid rst overrun", overrun, 0);
        check("mid rst busy", busy, 0);
        serial_in = 1'b1;
        step(2);
        reset = 1'b1;
        step(3);
        p0 = pulses;
        send_frame(8'h0F, 1'b1, 0, 0, c0);
        check("post-rst pulses", pulses - p0, 9);
        check("post-rst latency", rise_cyc - c0, SYNC + LAT);
        check("post-rst rx_valid", rx_valid, 1);
        check("post-rst s2p out", s2p_out, 8'h0F);
        check("post-rst overrun", overrun, 0);

        check("sr_clk low wider than 1 clk", wide_clk, 0);
        check("sr_read wider than 1 clk", wide_rd, 0);
        check("frame_err wider than 1 clk", wide_fe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
